// File: rtl/booth_mul_arbiter_if.sv
// Request/response and multiplier-side bundle for booth_mul_arbiter.
// The arbiter uses the slave view; requesters and the multiplier drive the master view.
interface booth_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int GW      = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [63:0]           rsp_result;
    logic                  rsp_error;
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;
    logic                  mul_en;
    logic                  mul_reset;
    logic [63:0]           mul_result;
    logic                  mul_done;
    logic                  busy;
    logic [GW-1:0]         grant_id;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_result, mul_done,
        output req_ready, rsp_valid, rsp_result, rsp_error,
               mul_a, mul_b, mul_en, mul_reset, busy, grant_id
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_result, mul_done,
        input  req_ready, rsp_valid, rsp_result, rsp_error,
               mul_a, mul_b, mul_en, mul_reset, busy, grant_id
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one sequential Booth multiplier between
// NUM_REQ requesters, with a watchdog that turns a missing done into an error reply.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a request; req_ready points at the RR winner
//   S_CLEAR | one cycle of mul_en+mul_reset to re-initialise the multiplier
//   S_RUN   | multiplier stepping; watchdog counting RUN cycles
//   S_RESP  | rsp_valid held one-hot at grant_id until that requester accepts
module booth_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 24,
    parameter int GW      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    booth_mul_arbiter_if.slave   bus
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_RESP
    } state_t;

    state_t               state_q;
    logic [GW-1:0]        last_grant_q;
    logic [GW-1:0]        grant_q;
    logic [31:0]          mul_a_q;
    logic [31:0]          mul_b_q;
    logic [63:0]          result_q;
    logic                 error_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 busy_q;
    logic                 mul_reset_q;
    logic                 run_q;
    logic [WDW-1:0]       wd_q;

    logic                 win_found;
    logic [GW-1:0]        win_idx;
    logic [GW-1:0]        scan_idx;
    logic [31:0]          sel_a;
    logic [31:0]          sel_b;

    // Scan starts one past the last served requester so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = GW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && bus.req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == win_idx) begin
                sel_a = bus.req_a[32*i +: 32];
                sel_b = bus.req_b[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            result_q     <= '0;
            error_q      <= 1'b0;
            rsp_valid_q  <= '0;
            busy_q       <= 1'b0;
            mul_reset_q  <= 1'b0;
            run_q        <= 1'b0;
            wd_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        mul_a_q     <= sel_a;
                        mul_b_q     <= sel_b;
                        grant_q     <= win_idx;
                        busy_q      <= 1'b1;
                        mul_reset_q <= 1'b1;
                        state_q     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    mul_reset_q <= 1'b0;
                    run_q       <= 1'b1;
                    wd_q        <= '0;
                    state_q     <= S_RUN;
                end
                S_RUN: begin
                    if (bus.mul_done) begin
                        result_q    <= bus.mul_result;
                        error_q     <= 1'b0;
                        run_q       <= 1'b0;
                        rsp_valid_q <= ONE_HOT0 << grant_q;
                        state_q     <= S_RESP;
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        result_q    <= '0;
                        error_q     <= 1'b1;
                        run_q       <= 1'b0;
                        rsp_valid_q <= ONE_HOT0 << grant_q;
                        state_q     <= S_RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready[grant_q]) begin
                        last_grant_q <= grant_q;
                        rsp_valid_q  <= '0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // req_ready is combinational, so it is gated by reset to keep every output low in reset.
    assign bus.req_ready  = (state_q == S_IDLE && win_found && !reset) ? (ONE_HOT0 << win_idx) : '0;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_error  = error_q;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    // Enable drops as soon as done is seen so the multiplier holds its product.
    assign bus.mul_en     = mul_reset_q | (run_q & ~bus.mul_done);
    assign bus.mul_reset  = mul_reset_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter with a behavioural Booth multiplier stand-in.
module tb_booth_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 24;
    localparam int GW      = 2;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_last = NUM_REQ - 1;

    booth_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .GW(GW)) bus ();

    booth_mul_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .GW(GW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    // Multiplier stand-in: 16 enabled non-clear cycles, then done registered and held.
    logic        tie_done0 = 1'b0;
    logic        m_done    = 1'b0;
    logic [63:0] m_result  = '0;
    int          m_cnt     = 0;
    assign bus.mul_done   = m_done;
    assign bus.mul_result = m_result;

    always @(posedge clk) begin
        if (bus.mul_en) begin
            if (bus.mul_reset) begin
                m_cnt  <= 0;
                m_done <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 15 && !tie_done0) begin
                    m_done   <= 1'b1;
                    m_result <= smul(bus.mul_a, bus.mul_b);
                end else begin
                    m_done <= 1'b0;
                end
            end
        end
        if (tie_done0) m_result <= 64'hDEAD_BEEF_0BAD_F00D;
    end

    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] vm);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (vm[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops(input logic [31:0] av [NUM_REQ], input logic [31:0] bv [NUM_REQ]);
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[32*i +: 32] = av[i];
            bus.req_b[32*i +: 32] = bv[i];
        end
    endtask

    task automatic run_one(input logic [NUM_REQ-1:0] vmask,
                           input logic [31:0] av [NUM_REQ], input logic [31:0] bv [NUM_REQ],
                           input int bp, input bit to, input logic [63:0] exp_res);
        int w;
        int n;
        logic [63:0] res0;
        w = rr_pick(exp_last, vmask);
        drive_ops(av, bv);
        bus.req_valid = vmask;
        #1;
        chk("req_ready", 64'(bus.req_ready), 64'(ONE << w));
        tick();
        bus.req_valid = '0;
        bus.req_a = {NUM_REQ{$urandom}};
        bus.req_b = {NUM_REQ{$urandom}};
        chk("clear_en_rst_busy", {61'd0, bus.mul_en, bus.mul_reset, bus.busy}, 64'd7);
        chk("grant_id", 64'(bus.grant_id), 64'(w));
        chk("mul_ab", {bus.mul_a, bus.mul_b}, {av[w], bv[w]});
        n = 1;
        while (bus.rsp_valid == '0 && n < 80) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), to ? 64'(TIMEOUT + 2) : 64'd19);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(ONE << w));
        chk("rsp_result", bus.rsp_result, exp_res);
        chk("rsp_error", 64'(bus.rsp_error), 64'(to));
        res0 = bus.rsp_result;
        bus.req_valid = '1;
        bus.rsp_ready = ~(ONE << w);
        for (int c = 0; c < bp; c++) begin
            tick();
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'(ONE << w));
            chk("bp_result", bus.rsp_result, res0);
            chk("bp_no_grant", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = '1;
        tick();
        chk("done_busy_valid", {63'd0, bus.busy} | 64'(bus.rsp_valid), 64'd0);
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        exp_last = w;
    endtask

    logic [31:0] av [NUM_REQ];
    logic [31:0] bv [NUM_REQ];

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        repeat (2) tick();
        bus.req_valid = '1;
        #1;
        chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset_outs", {58'd0, bus.busy, bus.mul_en, bus.mul_reset, bus.rsp_error, bus.grant_id}, 64'd0);
        chk("reset_rsp", 64'(bus.rsp_valid) | bus.rsp_result | {bus.mul_a, bus.mul_b}, 64'd0);
        bus.req_valid = '0;
        reset = 1'b0;
        tick();

        // single job on requester 0
        av[0] = 32'd3; bv[0] = 32'd5;
        run_one(4'b0001, av, bv, 0, 1'b0, 64'd15);

        // signed operands on requester 2
        av[2] = -32'sd7; bv[2] = 32'd6;
        run_one(4'b0100, av, bv, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFD6);
        av[2] = 32'h8000_0000; bv[2] = 32'h8000_0000;
        run_one(4'b0100, av, bv, 1, 1'b0, 64'h4000_0000_0000_0000);

        // reset pulse in IDLE, then all four requesting: order 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_last = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            av[i] = 32'(i + 1);
            bv[i] = 32'(i + 2);
        end
        run_one(4'b1111, av, bv, 0, 1'b0, 64'd2);
        run_one(4'b1111, av, bv, 5, 1'b0, 64'd6);
        run_one(4'b1111, av, bv, 0, 1'b0, 64'd12);
        run_one(4'b1111, av, bv, 2, 1'b0, 64'd20);
        run_one(4'b1111, av, bv, 0, 1'b0, 64'd2);

        // watchdog: multiplier never signals done
        tie_done0 = 1'b1;
        av[1] = 32'd9; bv[1] = 32'd9;
        run_one(4'b0010, av, bv, 0, 1'b1, 64'd0);
        tie_done0 = 1'b0;
        run_one(4'b0010, av, bv, 0, 1'b0, 64'd81);

        // reset in the middle of RUN (cycle T+8)
        av[3] = 32'd11; bv[3] = 32'd13;
        drive_ops(av, bv);
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        repeat (7) tick();
        bus.req_valid = '1;
        reset = 1'b1;
        #1;
        chk("midrst_outs", {58'd0, bus.busy, bus.mul_en, bus.mul_reset, bus.rsp_error, bus.grant_id}, 64'd0);
        chk("midrst_req_ready", 64'(bus.req_ready) | 64'(bus.rsp_valid), 64'd0);
        chk("midrst_regs", {bus.mul_a, bus.mul_b} | bus.rsp_result, 64'd0);
        tick();
        bus.req_valid = '0;
        reset = 1'b0;
        exp_last = NUM_REQ - 1;
        av[0] = 32'd1234; bv[0] = -32'sd77;
        run_one(4'b1111, av, bv, 0, 1'b0, smul(32'd1234, -32'sd77));

        // randomized jobs
        for (int j = 0; j < 16; j++) begin
            logic [NUM_REQ-1:0] vm;
            int w;
            vm = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                av[i] = $urandom;
                bv[i] = $urandom;
            end
            w = rr_pick(exp_last, vm);
            run_one(vm, av, bv, $urandom_range(0, 3), 1'b0, smul(av[w], bv[w]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=stuck expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
